// File: rtl/axi_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_pkg
// Shared definitions for the button-driven AXI-style master sequencer:
//   - state_e          : sequencer FSM states
//   - TIMEOUT_CYC_DEFAULT : default per-phase wait limit (cycles)
//   - hs_t / hs_decode : handshake-output bundle and its per-state decode
// ---------------------------------------------------------------------------
package axi_master_pkg;

  localparam int TIMEOUT_CYC_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_AW   = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  typedef struct packed {
    logic arvalid;
    logic rready;
    logic awvalid;
    logic wvalid;
  } hs_t;

  // Handshake levels driven while sitting in a given state. The write path
  // reuses the read-address channel to hand the target address to the slave.
  function automatic hs_t hs_decode(state_e s);
    hs_t h;
    h = '0;
    case (s)
      ST_RD_ADDR: h.arvalid = 1'b1;
      ST_RD_DATA: begin
        h.arvalid = 1'b1;
        h.rready  = 1'b1;
      end
      ST_WR_ADDR: h.arvalid = 1'b1;
      ST_WR_AW:   h.awvalid = 1'b1;
      ST_WR_DATA: begin
        h.awvalid = 1'b1;
        h.wvalid  = 1'b1;
      end
      default:    h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Two-flop synchronizer followed by a rising-edge detector for a raw,
// asynchronous push button.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   btn_i   in  raw button level
//   rise_o  out one-cycle pulse; high in the cycle after the button has been
//               seen high at two consecutive edges, so a consumer registering
//               on it acts at the 3rd edge after the first high sample
// ---------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/axi_master_seq.sv
// ---------------------------------------------------------------------------
// axi_master_seq
// Button-triggered master that performs a single read (memory[sw_addr] shown
// by the slave) or a copy-write (memory[sw_data] -> memory[sw_addr]) over a
// simple valid/ready slave interface, with a per-phase timeout.
// Ports:
//   clk, reset              clock / asynchronous active-high reset
//   btn_rd, btn_wr          raw request buttons (asynchronous)
//   sw_addr, sw_data        target address / write source index
//   ms_arvalid, SWM_arADDR  address channel (also used to load write target)
//   sm_arready              address accepted
//   ms_rready, sm_rvalid    read data handshake
//   ms_awvalid, sm_awready  write-address handshake
//   ms_wvalid, SWM_wdata    write-data valid and source index
//   sm_wready               write complete
//   busy                    FSM not idle
//   done                    one-cycle success pulse
//   err                     sticky timeout flag, cleared on next acceptance
// All outputs are flops; handshake outputs are decoded from the next state
// so they change in the same cycle the state does.
// ---------------------------------------------------------------------------
module axi_master_seq
  import axi_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_rd,
  input  logic       btn_wr,
  input  logic [3:0] sw_addr,
  input  logic [3:0] sw_data,
  output logic       ms_arvalid,
  output logic [3:0] SWM_arADDR,
  input  logic       sm_arready,
  output logic       ms_rready,
  input  logic       sm_rvalid,
  output logic       ms_awvalid,
  input  logic       sm_awready,
  output logic       ms_wvalid,
  output logic [3:0] SWM_wdata,
  input  logic       sm_wready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Phase counter value seen in the last allowed cycle of a phase: a phase
  // therefore lasts at most TIMEOUT_CYC cycles before falling into ERR.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic   rd_rise;
  logic   wr_rise;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d;
  hs_t        hs_q, hs_d;
  logic       busy_q, done_q;

  btn_sync_edge u_sync_rd (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_rd),
    .rise_o (rd_rise)
  );

  btn_sync_edge u_sync_wr (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_wr),
    .rise_o (wr_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        // Read wins over a simultaneous write; edges outside IDLE are lost.
        if (rd_rise || wr_rise) begin
          state_d = rd_rise ? ST_RD_ADDR : ST_WR_ADDR;
          addr_d  = sw_addr;
          data_d  = sw_data;
          err_d   = 1'b0;
        end
      end
      ST_RD_ADDR: begin
        cnt_d = cnt_q + 8'd1;
        if (sm_arready)             state_d = ST_RD_DATA;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_RD_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (sm_rvalid)              state_d = ST_DONE;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_WR_ADDR: begin
        cnt_d = cnt_q + 8'd1;
        if (sm_arready)             state_d = ST_WR_AW;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_WR_AW: begin
        cnt_d = cnt_q + 8'd1;
        if (sm_awready)             state_d = ST_WR_DATA;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_WR_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (sm_wready)              state_d = ST_DONE;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Every state entry restarts the phase count.
    if (state_d != state_q) cnt_d = 8'd0;
    if (state_d == ST_ERR)  err_d = 1'b1;

    hs_d = hs_decode(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 4'd0;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      hs_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      hs_q    <= hs_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign ms_arvalid = hs_q.arvalid;
  assign ms_rready  = hs_q.rready;
  assign ms_awvalid = hs_q.awvalid;
  assign ms_wvalid  = hs_q.wvalid;
  assign SWM_arADDR = addr_q;
  assign SWM_wdata  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_axi_master_seq.sv
// ---------------------------------------------------------------------------
// tb_axi_master_seq
// Table-driven bench for axi_master_seq with a small memory slave model.
// The slave raises each ready after its valid has been high for `stall`
// cycles; it never grants sm_awready for target address 0. A completed read
// loads the slave display with memory[address]; a completed write copies
// memory[SWM_wdata] into memory[address].
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_master_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_rd, btn_wr;
  logic [3:0] sw_addr, sw_data;
  logic       ms_arvalid, sm_arready, ms_rready, sm_rvalid;
  logic       ms_awvalid, sm_awready, ms_wvalid, sm_wready;
  logic [3:0] SWM_arADDR, SWM_wdata;
  logic       busy, done, err;

  always #5 clk = ~clk;

  axi_master_seq dut (
    .clk        (clk),
    .reset      (reset),
    .btn_rd     (btn_rd),
    .btn_wr     (btn_wr),
    .sw_addr    (sw_addr),
    .sw_data    (sw_data),
    .ms_arvalid (ms_arvalid),
    .SWM_arADDR (SWM_arADDR),
    .sm_arready (sm_arready),
    .ms_rready  (ms_rready),
    .sm_rvalid  (sm_rvalid),
    .ms_awvalid (ms_awvalid),
    .sm_awready (sm_awready),
    .ms_wvalid  (ms_wvalid),
    .SWM_wdata  (SWM_wdata),
    .sm_wready  (sm_wready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // ---------------- slave model ----------------
  logic [7:0] mem [16];
  logic [3:0] s_addr;
  logic [7:0] disp;
  int         stall;
  int         ar_cnt, r_cnt, aw_cnt, w_cnt;

  assign sm_arready = ms_arvalid && (ar_cnt >= stall);
  assign sm_rvalid  = ms_rready  && (r_cnt  >= stall);
  assign sm_awready = ms_awvalid && (s_addr != 4'd0) && (aw_cnt >= stall);
  assign sm_wready  = ms_wvalid  && (w_cnt  >= stall);

  always @(posedge clk) begin
    ar_cnt <= ms_arvalid ? ar_cnt + 1 : 0;
    r_cnt  <= ms_rready  ? r_cnt  + 1 : 0;
    aw_cnt <= ms_awvalid ? aw_cnt + 1 : 0;
    w_cnt  <= ms_wvalid  ? w_cnt  + 1 : 0;
    if (ms_arvalid && sm_arready) s_addr <= SWM_arADDR;
    if (ms_rready && sm_rvalid)   disp <= mem[s_addr];
    if (ms_wvalid && sm_wready)   mem[s_addr] <= mem[SWM_wdata];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         rd;
    int         wr;
    logic [3:0] addr;
    logic [3:0] data;
    int         stall;
    int         extra_at;   // busy cycle after which a second btn_rd is pressed (0 = none)
    int         exp_busy;
    int         exp_done;
    int         exp_err;
    int         exp_aw;
    int         chk_disp;
    logic [7:0] exp_disp;
  } vec_t;

  vec_t vecs [9];

  task automatic run_txn(input int idx, input vec_t v);
    int n, bcyc, dcnt, awc, addr_ok;
    stall   = v.stall;
    sw_addr = v.addr;
    sw_data = v.data;
    @(negedge clk);
    btn_rd = (v.rd != 0);
    btn_wr = (v.wr != 0);
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_latency", n, 3);
    btn_rd = 1'b0;
    btn_wr = 1'b0;
    bcyc    = 1;
    dcnt    = int'(done);
    awc     = int'(ms_awvalid);
    addr_ok = int'(SWM_arADDR == v.addr && SWM_wdata == v.data);
    while (busy && bcyc < 600) begin
      @(posedge clk); #1;
      dcnt += int'(done);
      if (busy) begin
        bcyc++;
        awc += int'(ms_awvalid);
        if (SWM_arADDR != v.addr || SWM_wdata != v.data) addr_ok = 0;
      end
      if (v.extra_at != 0 && bcyc == v.extra_at)     btn_rd = 1'b1;
      if (v.extra_at != 0 && bcyc == v.extra_at + 3) btn_rd = 1'b0;
    end
    check("busy_bounded", int'(bcyc < 600), 1);
    check("busy_cycles", bcyc, v.exp_busy);
    check("done_pulses", dcnt, v.exp_done);
    check("err_flag", int'(err), v.exp_err);
    check("awvalid_cycles", awc, v.exp_aw);
    check("latched_addr_data", addr_ok, 1);
    if (v.chk_disp != 0) check("slave_display", int'(disp), int'(v.exp_disp));
    $display("txn %0d rd=%0d wr=%0d addr=%0d data=%0d busy=%0d done=%0d err=%0d aw=%0d disp=%02h",
             idx, v.rd, v.wr, v.addr, v.data, bcyc, dcnt, err, awc, disp);
  endtask

  initial begin
    int seen, wait_n;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[5] = 8'h49;
    disp   = 8'h00;
    s_addr = 4'd0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    stall  = 0;

    //        rd wr addr  data  stall extra busy done err aw  chk disp
    vecs[0] = '{1, 0, 4'd5, 4'd0, 0, 0,   3, 1, 0,   0, 1, 8'h49};
    vecs[1] = '{0, 1, 4'd3, 4'd9, 0, 0,   4, 1, 0,   2, 0, 8'h00};
    vecs[2] = '{1, 0, 4'd3, 4'd0, 2, 0,   7, 1, 0,   0, 1, 8'h09};
    vecs[3] = '{0, 1, 4'd0, 4'd1, 0, 0, 257, 0, 1, 255, 0, 8'h00};
    vecs[4] = '{1, 0, 4'd7, 4'd0, 1, 0,   5, 1, 0,   0, 1, 8'h07};
    vecs[5] = '{1, 1, 4'd6, 4'd2, 0, 0,   3, 1, 0,   0, 1, 8'h06};
    vecs[6] = '{0, 1, 4'd2, 4'd5, 3, 0,  13, 1, 0,   8, 0, 8'h00};
    vecs[7] = '{1, 0, 4'd2, 4'd0, 0, 0,   3, 1, 0,   0, 1, 8'h49};
    vecs[8] = '{1, 0, 4'd5, 4'd0, 4, 2,  11, 1, 0,   0, 1, 8'h49};

    // Reset state, with switches set to non-zero to expose latch leakage.
    reset   = 1'b1;
    btn_rd  = 1'b0;
    btn_wr  = 1'b0;
    sw_addr = 4'hF;
    sw_data = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", int'({ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}), 0);
    check("rst_arADDR", int'(SWM_arADDR), 0);
    check("rst_wdata", int'(SWM_wdata), 0);
    check("rst_status", int'({busy, done, err}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(i, vecs[i]);
      repeat (2) @(negedge clk);
    end

    // The discarded second read must not start anything afterwards.
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    check("no_queued_request", seen, 0);

    // Reset asserted mid-read while in the data phase.
    stall   = 10;
    sw_addr = 4'd4;
    @(negedge clk);
    btn_rd = 1'b1;
    wait_n = 0;
    while (!ms_rready && wait_n < 40) begin
      @(posedge clk); #1;
      wait_n++;
    end
    btn_rd = 1'b0;
    check("reached_rd_data", int'(ms_rready), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valids", int'({ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}), 0);
    check("midrst_status", int'({busy, done}), 0);
    check("midrst_arADDR", int'(SWM_arADDR), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    check("post_reset_idle", seen, 0);
    $display("txn reset-in-rd_data: busy=%0d done=%0d", busy, done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_master_seq.md
AXI_MASTER_SEQ -- requirements
Module: axi_master_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max cycles any single phase may wait for a slave response.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 btn_rd  in  1  raw read-request button, asynchronous to clk.
REQ-005 btn_wr  in  1  raw write-request button, asynchronous to clk.
REQ-006 sw_addr  in  4  target memory address.
REQ-007 sw_data  in  4  source index for a write (copy memory[sw_data] to memory[sw_addr]).
REQ-008 ms_arvalid  out  1  address-valid to the slave.
REQ-009 SWM_arADDR  out  4  address to the slave.
REQ-010 sm_arready  in  1  address accepted by the slave.
REQ-011 ms_rready  out  1  master ready for read data.
REQ-012 sm_rvalid  in  1  read data valid from the slave.
REQ-013 ms_awvalid  out  1  write-address valid.
REQ-014 sm_awready  in  1  write-address accepted.
REQ-015 ms_wvalid  out  1  write-data valid.
REQ-016 SWM_wdata  out  4  write source index.
REQ-017 sm_wready  in  1  write complete.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.
REQ-019 done  out  1  one-cycle pulse on successful completion.
REQ-020 err  out  1  sticky timeout flag; cleared when the next request is accepted.

Function
REQ-021 Each button SHALL pass through a 2-flop synchronizer plus a rising-edge detector; the request is acted on at the 3rd clock edge after the button is first sampled high.
REQ-022 Requests SHALL be accepted only in IDLE; edges arriving while busy SHALL be discarded, not queued.
REQ-023 Simultaneous rd and wr edges in IDLE SHALL start a read; the write is discarded.
REQ-024 On acceptance, sw_addr and sw_data SHALL be latched; SWM_arADDR and SWM_wdata SHALL hold the latched values until IDLE is re-entered.
REQ-025 States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_AW, WR_DATA, DONE, ERR.
REQ-026 RD_ADDR: ms_arvalid=1; go to RD_DATA on sm_arready=1.
REQ-027 RD_DATA: ms_arvalid=1, ms_rready=1; go to DONE on sm_rvalid=1.
REQ-028 WR_ADDR: ms_arvalid=1, which loads the target address into the slave; go to WR_AW on sm_arready=1.
REQ-029 WR_AW: ms_arvalid=0, ms_awvalid=1; go to WR_DATA on sm_awready=1.
REQ-030 WR_DATA: ms_awvalid=1, ms_wvalid=1; go to DONE on sm_wready=1.
REQ-031 If the ready input is already high on the first cycle of a state, the FSM SHALL leave that state at the next edge (one-cycle minimum per state).
REQ-032 DONE: all valid/ready outputs low, done=1 for exactly one cycle, then IDLE.
REQ-033 An 8-bit phase counter SHALL clear on every state entry and increment each cycle in RD_*/WR_* states; on reaching TIMEOUT_CYC the FSM SHALL go to ERR.
REQ-034 ERR: all handshake outputs low, err set, done not pulsed, then IDLE next cycle.
REQ-035 A write with latched address 0 SHALL never receive sm_awready, so it SHALL terminate through ERR.
REQ-036 Handshake outputs SHALL be registered (no combinational path from sm_* inputs to ms_* outputs).

Reset
REQ-037 Reset SHALL force IDLE and set all outputs to 0 (SWM_arADDR=0, SWM_wdata=0, busy=0, done=0, err=0), clear the synchronizers, edge detectors and counter, and clear the latched address and data.
REQ-038 Reset asserted mid-transaction SHALL drop all valids within the reset assertion, with no done pulse.

Structure
REQ-039 Package axi_master_pkg SHALL hold the state enum and the TIMEOUT_CYC default.
REQ-040 Sub-module btn_sync_edge SHALL implement the synchronizer plus edge detector and be instantiated twice.

Verification
REQ-041 With the existing slave model, sw_addr=5, pulse btn_rd: sequence RD_ADDR->RD_DATA->DONE; done pulses once; slave display shows 0x49.
REQ-042 sw_addr=3, sw_data=9, pulse btn_wr, then read address 3: done pulses after the write; the read shows "9" (0x09).
REQ-043 sw_addr=0, btn_wr: ms_awvalid is held for 255 cycles, then err=1, done=0, busy=0.
REQ-044 btn_rd and btn_wr rise on the same edge: only the read is performed; no write handshake appears.
REQ-045 Assert reset while in RD_DATA: all ms_* outputs go to 0 immediately; after release, busy=0.
REQ-046 A second btn_rd edge while busy is ignored; exactly one done pulse results.
